fwd_scoreboard: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the Mini-RISC-V integer pipeline. It sits beside the EX stage.
- It tracks destination registers of in-flight producers in an internal NSTAGES-deep shift register and selects the youngest valid producer for each EX operand.
- When the youngest matching producer is a load whose data is not yet available, it stalls EX instead of falling through to an older producer.
- A saturating stall-cycle counter is kept for performance monitoring.

---
 rtl/fwd_scoreboard.sv | 100 ++++++++++
 tb/tb_fwd_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit beside the EX stage of the integer pipeline.
// Selects, operand data and stall are combinational; producer tracking updates one cycle later.
// Stall holds IF/ID/EX and inserts a bubble; the producer history keeps shifting so a stalled load drains.
module fwd_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NSTAGES  = 3,
  parameter int REG_BITS = 5,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(NSTAGES + 1)
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic                    ex_valid,
  input  logic                    ex_regwrite,
  input  logic                    ex_memread,
  input  logic [REG_BITS-1:0]     ex_rd,
  input  logic [REG_BITS-1:0]     ex_rs1,
  input  logic [REG_BITS-1:0]     ex_rs2,
  input  logic [XLEN-1:0]         rf_rs1,
  input  logic [XLEN-1:0]         rf_rs2,
  input  logic [NSTAGES*XLEN-1:0] stage_res,
  input  logic                    alusrc,
  input  logic [XLEN-1:0]         imm,
  input  logic                    flush,
  output logic [XLEN-1:0]         fw_rs1,
  output logic [XLEN-1:0]         fw_rs2,
  output logic [XLEN-1:0]         rs2_mod,
  output logic [SELW-1:0]         fw_sel1,
  output logic [SELW-1:0]         fw_sel2,
  output logic                    stall,
  output logic [31:0]             stall_cycles
);

  // Producer history: index 0 is EX/MEM, higher indices are older stages.
  logic [NSTAGES-1:0]               v_q, v_d;
  logic [NSTAGES-1:0]               ld_q, ld_d;
  logic [NSTAGES-1:0][REG_BITS-1:0] rd_q, rd_d;
  logic [31:0]                      cnt_q, cnt_d;

  logic haz1, haz2;
  logic rec;

  // Operand select: scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fw_sel1 = '0;
    fw_sel2 = '0;
    fw_rs1  = rf_rs1;
    rs2_mod = rf_rs2;
    haz1    = 1'b0;
    haz2    = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (v_q[k] && (rd_q[k] == ex_rs1) && (ex_rs1 != '0)) begin
        fw_sel1 = SELW'(k + 1);
        fw_rs1  = stage_res[k*XLEN +: XLEN];
        haz1    = ld_q[k] && (k < LOAD_LAT);
      end
      if (v_q[k] && (rd_q[k] == ex_rs2) && (ex_rs2 != '0)) begin
        fw_sel2 = SELW'(k + 1);
        rs2_mod = stage_res[k*XLEN +: XLEN];
        haz2    = ld_q[k] && (k < LOAD_LAT);
      end
    end
  end

  // The rs2 hazard counts even with an immediate operand, since store data still needs it.
  assign stall  = ex_valid && !flush && (haz1 || haz2);
  assign fw_rs2 = alusrc ? imm : rs2_mod;

  // Only a live, non-stalled, non-flushed write to a real register becomes a producer.
  assign rec = ex_valid && ex_regwrite && (ex_rd != '0) && !stall && !flush;

  // Next-state: shift the history by one stage and bump the saturating stall counter.
  always_comb begin
    v_d   = {v_q[NSTAGES-2:0], rec};
    ld_d  = {ld_q[NSTAGES-2:0], ex_memread};
    rd_d  = {rd_q[NSTAGES-2:0], ex_rd};
    cnt_d = cnt_q;
    if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      v_q   <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus a randomized run against a history-queue model.
module tb_fwd_scoreboard;
  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int LL   = 1;
  localparam int SW   = $clog2(NS + 1);

  logic            clk = 1'b0;
  logic            Rst;
  logic            ex_valid, ex_regwrite, ex_memread, alusrc, flush;
  logic [4:0]      ex_rd, ex_rs1, ex_rs2;
  logic [XLEN-1:0] rf_rs1, rf_rs2, imm;
  logic [NS*XLEN-1:0] stage_res;
  logic [XLEN-1:0] fw_rs1, fw_rs2, rs2_mod;
  logic [SW-1:0]   fw_sel1, fw_sel2;
  logic            stall;
  logic [31:0]     stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.XLEN(XLEN), .NSTAGES(NS), .REG_BITS(5), .LOAD_LAT(LL)) dut (
    .clk(clk), .Rst(Rst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .stage_res(stage_res), .alusrc(alusrc),
    .imm(imm), .flush(flush), .fw_rs1(fw_rs1), .fw_rs2(fw_rs2), .rs2_mod(rs2_mod),
    .fw_sel1(fw_sel1), .fw_sel2(fw_sel2), .stall(stall), .stall_cycles(stall_cycles)
  );

  // Reference model: list of the most recent NS issue slots, youngest first.
  typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
  ent_t      hist[$];
  bit [31:0] m_cnt;

  function automatic int find_prod(input logic [4:0] rs);
    if (rs == 5'd0) return -1;
    for (int i = 0; i < NS; i++)
      if (hist[i].v && hist[i].rd == rs) return i;
    return -1;
  endfunction

  function automatic bit m_stall();
    int a, b;
    bit h;
    a = find_prod(ex_rs1);
    b = find_prod(ex_rs2);
    h = (a >= 0 && hist[a].ld && a < LL) || (b >= 0 && hist[b].ld && b < LL);
    return ex_valid && !flush && h;
  endfunction

  task automatic tick();
    bit   st;
    ent_t e;
    st = m_stall();
    @(posedge clk);
    if (Rst) begin
      foreach (hist[i]) hist[i].v = 1'b0;
      m_cnt = 32'd0;
    end else begin
      e.v  = ex_valid && ex_regwrite && ex_rd != 5'd0 && !st && !flush;
      e.rd = ex_rd;
      e.ld = ex_memread;
      hist.push_front(e);
      void'(hist.pop_back());
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0; alusrc = 1'b0; flush = 1'b0;
    ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0; rf_rs1 = '0; rf_rs2 = '0; imm = '0; stage_res = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input bit wr, input bit ld);
    idle_inputs();
    ex_valid = 1'b1; ex_regwrite = wr; ex_memread = ld; ex_rd = rd;
    #1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    ex_valid = 1'b1; ex_rs1 = 5'd5; rf_rs1 = 32'h11; rf_rs2 = 32'h22; ex_rs2 = 5'd6;
    #1;
    n_checks++; if (fw_sel1 !== 0) begin n_fail++; $display("FAIL reset_sel1 got %0d want 0", fw_sel1); end
    n_checks++; if (fw_rs1 !== 32'h11) begin n_fail++; $display("FAIL reset_rs1 got %h want 11", fw_rs1); end
    n_checks++; if (rs2_mod !== 32'h22) begin n_fail++; $display("FAIL reset_rs2mod got %h want 22", rs2_mod); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", stall_cycles); end
  endtask

  task automatic test_alu_forward();
    do_reset();
    issue(5'd5, 1'b1, 1'b0);
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd6; ex_rs1 = 5'd5;
    rf_rs1 = 32'h11; stage_res = {32'h0, 32'h0, 32'hAB};
    #1;
    n_checks++; if (fw_sel1 !== 1) begin n_fail++; $display("FAIL alu_sel1 got %0d want 1", fw_sel1); end
    n_checks++; if (fw_rs1 !== 32'hAB) begin n_fail++; $display("FAIL alu_rs1 got %h want ab", fw_rs1); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", stall); end
  endtask

  task automatic test_youngest();
    do_reset();
    issue(5'd7, 1'b1, 1'b0);
    issue(5'd7, 1'b1, 1'b0);
    ex_valid = 1'b1; ex_rs2 = 5'd7; alusrc = 1'b0; imm = 32'h55;
    rf_rs2 = 32'h99; stage_res = {32'h3, 32'h1, 32'h2};
    #1;
    n_checks++; if (fw_sel2 !== 1) begin n_fail++; $display("FAIL young_sel2 got %0d want 1", fw_sel2); end
    n_checks++; if (fw_rs2 !== 32'h2) begin n_fail++; $display("FAIL young_rs2 got %h want 2", fw_rs2); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd9, 1'b1, 1'b1);
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd10; ex_rs1 = 5'd9;
    stage_res = {32'h0, 32'hBEEF, 32'hDEAD};
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop got %b want 0", stall); end
    n_checks++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", stall_cycles); end
    n_checks++; if (fw_sel1 !== 2) begin n_fail++; $display("FAIL lu_sel1 got %0d want 2", fw_sel1); end
    n_checks++; if (fw_rs1 !== 32'hBEEF) begin n_fail++; $display("FAIL lu_rs1 got %h want beef", fw_rs1); end
  endtask

  task automatic test_store_alusrc();
    do_reset();
    issue(5'd9, 1'b1, 1'b1);
    ex_valid = 1'b1; ex_rs2 = 5'd9; alusrc = 1'b1; imm = 32'h10;
    stage_res = {32'h0, 32'hCAFE, 32'h1234};
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL st_stall got %b want 1", stall); end
    n_checks++; if (fw_rs2 !== 32'h10) begin n_fail++; $display("FAIL st_fwrs2 got %h want 10", fw_rs2); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_stall_drop got %b want 0", stall); end
    n_checks++; if (rs2_mod !== 32'hCAFE) begin n_fail++; $display("FAIL st_rs2mod got %h want cafe", rs2_mod); end
    n_checks++; if (fw_sel2 !== 2) begin n_fail++; $display("FAIL st_sel2 got %0d want 2", fw_sel2); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(5'd9, 1'b1, 1'b1);
    ex_valid = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd12; ex_rs1 = 5'd9; flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall got %b want 0", stall); end
    tick();
    idle_inputs();
    ex_valid = 1'b1; ex_rs1 = 5'd9; ex_rs2 = 5'd12;
    #1;
    n_checks++; if (fw_sel2 !== 0) begin n_fail++; $display("FAIL fl_sel2 got %0d want 0", fw_sel2); end
    n_checks++; if (fw_sel1 !== 2) begin n_fail++; $display("FAIL fl_sel1 got %0d want 2", fw_sel1); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL fl_cnt got %0d want 0", stall_cycles); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(5'd9, 1'b1, 1'b1);
    ex_valid = 1'b1; ex_rs1 = 5'd9; rf_rs1 = 32'h77;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_pre got %b want 1", stall); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall got %b want 0", stall); end
    n_checks++; if (fw_sel1 !== 0) begin n_fail++; $display("FAIL rms_sel1 got %0d want 0", fw_sel1); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rms_cnt got %0d want 0", stall_cycles); end
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int r = 0; r < 2; r++) begin
      issue(5'd9, 1'b1, 1'b1);
      ex_valid = 1'b1; ex_rs1 = 5'd9;
      #1;
      tick();
      n_checks++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL sat_cnt round %0d got %h want ffffffff", r, stall_cycles);
      end
    end
  endtask

  task automatic test_x0();
    do_reset();
    issue(5'd0, 1'b1, 1'b1);
    ex_valid = 1'b1; ex_rs1 = 5'd0; ex_rs2 = 5'd0; rf_rs1 = 32'h5; rf_rs2 = 32'h6;
    stage_res = {32'h1, 32'h2, 32'h3};
    #1;
    n_checks++; if (fw_sel1 !== 0) begin n_fail++; $display("FAIL x0_sel1 got %0d want 0", fw_sel1); end
    n_checks++; if (fw_sel2 !== 0) begin n_fail++; $display("FAIL x0_sel2 got %0d want 0", fw_sel2); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b want 0", stall); end
    n_checks++; if (fw_rs1 !== 32'h5) begin n_fail++; $display("FAIL x0_rs1 got %h want 5", fw_rs1); end
  endtask

  task automatic test_random();
    int a, b;
    logic [XLEN-1:0] e1, e2m, e2;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      Rst         = ($urandom_range(0, 49) == 0);
      ex_valid    = ($urandom_range(0, 9) != 0);
      ex_regwrite = ($urandom_range(0, 3) != 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      alusrc      = $urandom_range(0, 1) == 1;
      flush       = ($urandom_range(0, 9) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_rs1      = 5'($urandom_range(0, 3));
      ex_rs2      = 5'($urandom_range(0, 3));
      rf_rs1      = $urandom; rf_rs2 = $urandom; imm = $urandom;
      stage_res   = {$urandom, $urandom, $urandom};
      #1;
      a   = find_prod(ex_rs1);
      b   = find_prod(ex_rs2);
      e1  = (a < 0) ? rf_rs1 : stage_res[a*XLEN +: XLEN];
      e2m = (b < 0) ? rf_rs2 : stage_res[b*XLEN +: XLEN];
      e2  = alusrc ? imm : e2m;
      n_checks++; if (fw_sel1 !== SW'(a + 1)) begin n_fail++; $display("FAIL rnd_sel1 cyc %0d got %0d want %0d", c, fw_sel1, a + 1); end
      n_checks++; if (fw_sel2 !== SW'(b + 1)) begin n_fail++; $display("FAIL rnd_sel2 cyc %0d got %0d want %0d", c, fw_sel2, b + 1); end
      n_checks++; if (fw_rs1 !== e1) begin n_fail++; $display("FAIL rnd_rs1 cyc %0d got %h want %h", c, fw_rs1, e1); end
      n_checks++; if (rs2_mod !== e2m) begin n_fail++; $display("FAIL rnd_rs2mod cyc %0d got %h want %h", c, rs2_mod, e2m); end
      n_checks++; if (fw_rs2 !== e2) begin n_fail++; $display("FAIL rnd_fwrs2 cyc %0d got %h want %h", c, fw_rs2, e2); end
      n_checks++; if (stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, stall, m_stall()); end
      n_checks++; if (stall_cycles !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, stall_cycles, m_cnt); end
      tick();
    end
    Rst = 1'b0;
  endtask

  initial begin
    ent_t z;
    z.v = 1'b0; z.rd = '0; z.ld = 1'b0;
    for (int i = 0; i < NS; i++) hist.push_back(z);
    m_cnt = 32'd0;
    Rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_alu_forward();
    test_youngest();
    test_load_use();
    test_store_alusrc();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_x0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
